// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package reset_pkg;

   typedef enum logic [1:0] {
      RS_HOLD,
      RS_RELEASE,
      RS_RUN,
      RS_SOFT
   } rst_state_t;

   // One spare bit over the larger terminal count keeps the compare simple.
   function automatic int cnt_width(input int stage_dly, input int soft_len);
      return $clog2((stage_dly > soft_len) ? stage_dly : soft_len) + 1;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Soft-reset request and staged reset outputs between the SPI register space and the sequencer.
interface reset_sequencer_if #(
   parameter int NUM_STAGES = 3
);
   logic                  soft_rst_req;
   logic [NUM_STAGES-1:0] stage_rst;
   logic [NUM_STAGES-1:0] stage_rst_n;
   logic                  rst_done;
   logic                  soft_rst_busy;

   modport master (
      output soft_rst_req,
      input  stage_rst, stage_rst_n, rst_done, soft_rst_busy
   );

   modport slave (
      input  soft_rst_req,
      output stage_rst, stage_rst_n, rst_done, soft_rst_busy
   );
endinterface

// File: rtl/reset_sequencer_dly_cnt.sv
// Terminal-count delay counter shared by the HOLD, RELEASE and SOFT phases.
module rst_dly_cnt #(
   parameter int WIDTH = 5
) (
   input  logic             sync_clk,
   input  logic             sync_rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] term_val,
   output logic             done
);
   logic [WIDTH-1:0] cnt;

   assign done = (cnt == term_val);

   // Self-clears at the terminal count so it never wraps.
   always_ff @(posedge sync_clk or posedge sync_rst) begin
      if (sync_rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= done ? '0 : cnt + WIDTH'(1);
   end
endmodule

// File: rtl/reset_sequencer.sv
// Releases per-subsystem resets one at a time after sync_rst drops, and replays
// the sequence on a soft-reset request.
module reset_sequencer
   import reset_pkg::*;
#(
   parameter int NUM_STAGES   = 3,
   parameter int STAGE_DLY    = 16,
   parameter int SOFT_RST_LEN = 8
) (
   input logic              sync_clk,
   input logic              sync_rst,
   reset_sequencer_if.slave bus
);
   localparam int CNT_W = cnt_width(STAGE_DLY, SOFT_RST_LEN);
   localparam int IDX_W = $clog2(NUM_STAGES + 1);
   localparam logic [CNT_W-1:0] STAGE_TERM = CNT_W'(STAGE_DLY - 1);
   localparam logic [CNT_W-1:0] SOFT_TERM  = CNT_W'(SOFT_RST_LEN - 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_STAGES - 1);

   if (NUM_STAGES < 1) begin : g_bad_stages
      $error("reset_sequencer: NUM_STAGES must be >= 1");
   end
   if (STAGE_DLY < 1) begin : g_bad_dly
      $error("reset_sequencer: STAGE_DLY must be >= 1");
   end
   if (SOFT_RST_LEN < 1) begin : g_bad_soft
      $error("reset_sequencer: SOFT_RST_LEN must be >= 1");
   end

   rst_state_t            state, state_nxt;
   logic [IDX_W-1:0]      idx, idx_nxt;
   logic [NUM_STAGES-1:0] stage_q, stage_nxt;
   logic [NUM_STAGES-1:0] stage_n_q;
   logic                  done_q, done_nxt;
   logic                  busy_q, busy_nxt;
   logic                  cnt_clr, cnt_en, cnt_done;
   logic [CNT_W-1:0]      term_val;

   rst_dly_cnt #(.WIDTH(CNT_W)) u_dly_cnt (
      .sync_clk (sync_clk),
      .sync_rst (sync_rst),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .term_val (term_val),
      .done     (cnt_done)
   );

   // Every output is registered; the complement gets its own flops.
   always_ff @(posedge sync_clk or posedge sync_rst) begin
      if (sync_rst) begin
         state     <= RS_HOLD;
         idx       <= '0;
         stage_q   <= '1;
         stage_n_q <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         stage_q   <= stage_nxt;
         stage_n_q <= ~stage_nxt;
         done_q    <= done_nxt;
         busy_q    <= busy_nxt;
      end
   end

   // A soft request overrides whatever phase is in progress.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      stage_nxt = stage_q;
      done_nxt  = done_q;
      busy_nxt  = busy_q;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      term_val  = STAGE_TERM;

      if (bus.soft_rst_req) begin
         state_nxt = RS_SOFT;
         idx_nxt   = '0;
         stage_nxt = '1;
         done_nxt  = 1'b0;
         busy_nxt  = 1'b1;
         cnt_clr   = 1'b1;
      end else begin
         case (state)
            RS_HOLD: begin
               cnt_en = 1'b1;
               if (cnt_done) begin
                  stage_nxt[0] = 1'b0;
                  idx_nxt      = IDX_W'(1);
                  if (NUM_STAGES == 1) begin
                     state_nxt = RS_RUN;
                     done_nxt  = 1'b1;
                     busy_nxt  = 1'b0;
                  end else begin
                     state_nxt = RS_RELEASE;
                  end
               end
            end
            RS_RELEASE: begin
               cnt_en = 1'b1;
               if (cnt_done) begin
                  for (int i = 0; i < NUM_STAGES; i++) begin
                     if (idx == IDX_W'(i))
                        stage_nxt[i] = 1'b0;
                  end
                  if (idx == LAST_IDX) begin
                     state_nxt = RS_RUN;
                     done_nxt  = 1'b1;
                     busy_nxt  = 1'b0;
                  end else begin
                     idx_nxt = idx + IDX_W'(1);
                  end
               end
            end
            RS_SOFT: begin
               cnt_en   = 1'b1;
               term_val = SOFT_TERM;
               if (cnt_done) begin
                  state_nxt = RS_HOLD;
                  idx_nxt   = '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.stage_rst     = stage_q;
   assign bus.stage_rst_n   = stage_n_q;
   assign bus.rst_done      = done_q;
   assign bus.soft_rst_busy = busy_q;
endmodule
